// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue
// Description : Instruction fetch stage. Owns the PC, drives the instruction
//               memory address and Stand-by request, captures returned words
//               into a tagged FIFO for decode, handles redirects and WFI
//               sleep/wake sequencing.
//               Optional build macro IFETCH_SLEEP_CNT_EN adds the
//               saturating sleep_cycles counter output.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        wfi_req,
    input  logic [31:0] wfi_pc,
    input  logic        irq_pending,
    output logic [31:0] imem_addr,
    output logic        imem_wfi,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        sleeping
`ifdef IFETCH_SLEEP_CNT_EN
    ,
    output logic [31:0] sleep_cycles
`endif
);

    localparam int c_PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_OCC_W = c_CNT_W + 1;
    localparam logic [c_OCC_W-1:0] c_DEPTH = c_OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SLEEP = 2'd1,
        ST_WAKE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_fetch_pc;
    logic [31:0]          w_fetch_pc_nxt;
    logic                 r_inflight;
    logic [31:0]          r_inflight_pc;
    logic [31:0]          r_q_data [DEPTH];
    logic [31:0]          r_q_pc   [DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_wfi_take;
    logic                 w_flush;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_issue;
    logic [c_OCC_W-1:0]   w_occ;

    // A WFI only counts in RUN and loses to a coincident redirect.
    assign w_wfi_take = (r_state == ST_RUN) && wfi_req && !redirect_valid;
    assign w_flush    = redirect_valid || w_wfi_take;

    assign inst_valid = (r_count != '0);
    assign w_pop      = inst_valid && inst_ready;
    // The word arriving this cycle belongs to last cycle's issue; a flush
    // in this cycle is what discards it.
    assign w_push     = r_inflight && !w_flush;

    // Occupancy after this cycle's pop, counting the word still in flight.
    assign w_occ   = {1'b0, r_count} - c_OCC_W'(w_pop) + c_OCC_W'(r_inflight);
    assign w_issue = (r_state == ST_RUN) && !w_flush && (w_occ < c_DEPTH);

    assign imem_addr = r_fetch_pc;
    assign imem_wfi  = (r_state == ST_SLEEP);
    assign sleeping  = (r_state == ST_SLEEP);
    assign inst_data = r_q_data[r_rd_ptr];
    assign inst_pc   = r_q_pc[r_rd_ptr];

    // Sleep/wake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: WAKE always lasts exactly one cycle for Stand-by exit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_wfi_take && !irq_pending) begin
                    w_state_nxt = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (irq_pending || redirect_valid) begin
                    w_state_nxt = ST_WAKE;
                end
            end
            ST_WAKE: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Next fetch PC: redirect, then WFI resume address, then sequential.
    always_comb begin
        w_fetch_pc_nxt = r_fetch_pc;
        if (redirect_valid) begin
            w_fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
        end else if (w_wfi_take) begin
            w_fetch_pc_nxt = {wfi_pc[31:2], 2'b00};
        end else if (w_issue) begin
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end
    end

    // PC register and in-flight tag for the word being read this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= {RESET_PC[31:2], 2'b00};
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
            end
        end
    end

    // Instruction FIFO; a flush empties it and overrides any push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_q_data[r_wr_ptr] <= imem_rdata;
                r_q_pc[r_wr_ptr]   <= r_inflight_pc;
                r_wr_ptr           <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

`ifdef IFETCH_SLEEP_CNT_EN
    logic [31:0] r_sleep_cnt;

    // Saturating count of cycles spent in SLEEP; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sleep_cnt <= '0;
        end else if ((r_state == ST_SLEEP) && (r_sleep_cnt != 32'hFFFF_FFFF)) begin
            r_sleep_cnt <= r_sleep_cnt + 32'd1;
        end
    end

    assign sleep_cycles = r_sleep_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_queue
// Description : Directed self-checking bench for ifetch_queue with an
//               expected-PC scoreboard popped whenever decode accepts a word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        wfi_req = 1'b0;
    logic [31:0] wfi_pc = '0;
    logic        irq_pending = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_wfi;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        sleeping;
`ifdef IFETCH_SLEEP_CNT_EN
    logic [31:0] sleep_cycles;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] sb[$];
    logic [31:0] r_prev_addr = '0;

    ifetch_queue #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .wfi_req        (wfi_req),
        .wfi_pc         (wfi_pc),
        .irq_pending    (irq_pending),
        .imem_addr      (imem_addr),
        .imem_wfi       (imem_wfi),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .sleeping       (sleeping)
`ifdef IFETCH_SLEEP_CNT_EN
        ,
        .sleep_cycles   (sleep_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    // Instruction memory model: word for last cycle's address.
    always @(posedge clk) r_prev_addr <= imem_addr;
    assign imem_rdata = mem_word(r_prev_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // End the current cycle: compare any accepted word against the scoreboard.
    task automatic cyc();
        logic [31:0] exp_pc;
        if (inst_valid && inst_ready) begin
            exp_pc = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
            check("sb_pc", inst_pc, exp_pc);
            check("sb_data", inst_data, mem_word(exp_pc));
        end
        @(posedge clk);
        #1;
    endtask

    // Cycles in which a fetch is expected to issue at start+4*i.
    task automatic fetch_cycles(input int n, input logic [31:0] start);
        logic [31:0] exp_addr;
        for (int i = 0; i < n; i++) begin
            exp_addr = start + 32'(4 * i);
            check("imem_addr", imem_addr, exp_addr);
            sb.push_back(exp_addr);
            cyc();
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_addr"},  imem_addr, 32'h0);
        check({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        check({tag, "_wfi"},   {31'd0, imem_wfi}, 32'd0);
        check({tag, "_sleep"}, {31'd0, sleeping}, 32'd0);
        check({tag, "_data"},  inst_data, 32'h0);
        check({tag, "_pc"},    inst_pc, 32'h0);
`ifdef IFETCH_SLEEP_CNT_EN
        check({tag, "_scnt"},  sleep_cycles, 32'h0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset values
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_checks("rst0");
        rst_n = 1'b1;

        // ---- sequential fetch, ready=1
        for (int k = 0; k < 6; k++) begin
            check("t1_valid", {31'd0, inst_valid}, {31'd0, (k >= 2)});
            fetch_cycles(1, 32'(4 * k));
        end

        // ---- back-pressure after a fresh reset
        rst_n = 1'b0;
        inst_ready = 1'b0;
        #1;
        reset_checks("rst1");
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", {31'd0, inst_valid}, {31'd0, (k >= 2)});
            if (k >= 2) check("bp_head", inst_pc, 32'h0);
            if (k < 2) begin
                fetch_cycles(1, 32'(4 * k));
            end else begin
                check("bp_addr", imem_addr, 32'h8);
                cyc();
            end
        end
        inst_ready = 1'b1;
        for (int k = 10; k < 13; k++) begin
            check("bp_rel_valid", {31'd0, inst_valid}, 32'd1);
            fetch_cycles(1, 32'(8 + 4 * (k - 10)));
        end

        // ---- redirect with queue occupied and a fetch in flight
        inst_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        cyc();
        redirect_valid = 1'b0;
        sb.delete();
        inst_ready = 1'b1;
        check("rd_valid1", {31'd0, inst_valid}, 32'd0);
        fetch_cycles(1, 32'h100);
        check("rd_valid2", {31'd0, inst_valid}, 32'd0);
        fetch_cycles(1, 32'h104);
        check("rd_valid3", {31'd0, inst_valid}, 32'd1);
        check("rd_pc3", inst_pc, 32'h100);
        fetch_cycles(1, 32'h108);
        fetch_cycles(3, 32'h10C);

        // ---- WFI sleep for 20 cycles, wake on irq
        wfi_req = 1'b1;
        wfi_pc = 32'h0000_0042;
        cyc();
        wfi_req = 1'b0;
        sb.delete();
        for (int i = 1; i <= 20; i++) begin
            check("sl_wfi", {31'd0, imem_wfi}, 32'd1);
            check("sl_sleeping", {31'd0, sleeping}, 32'd1);
            check("sl_valid", {31'd0, inst_valid}, 32'd0);
            if (i == 20) irq_pending = 1'b1;
            cyc();
        end
        check("wk_wfi", {31'd0, imem_wfi}, 32'd0);
        check("wk_sleeping", {31'd0, sleeping}, 32'd0);
        check("wk_addr_hold", imem_addr, 32'h40);
`ifdef IFETCH_SLEEP_CNT_EN
        check("wk_sleep_cycles", sleep_cycles, 32'd20);
`endif
        cyc();
        irq_pending = 1'b0;
        fetch_cycles(1, 32'h40);
        fetch_cycles(4, 32'h44);

        // ---- WFI coincident with redirect: redirect wins
        wfi_req = 1'b1;
        wfi_pc = 32'h40;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        cyc();
        wfi_req = 1'b0;
        redirect_valid = 1'b0;
        sb.delete();
        check("wr_wfi", {31'd0, imem_wfi}, 32'd0);
        check("wr_sleeping", {31'd0, sleeping}, 32'd0);
        fetch_cycles(5, 32'h200);
        check("wr_wfi_after", {31'd0, imem_wfi}, 32'd0);

        // ---- WFI with irq already pending: acts as redirect
        irq_pending = 1'b1;
        wfi_req = 1'b1;
        wfi_pc = 32'h0000_0081;
        cyc();
        wfi_req = 1'b0;
        sb.delete();
        check("wi_sleeping", {31'd0, sleeping}, 32'd0);
        fetch_cycles(5, 32'h80);
        irq_pending = 1'b0;

        // ---- reset while sleeping
        wfi_req = 1'b1;
        wfi_pc = 32'h300;
        cyc();
        wfi_req = 1'b0;
        sb.delete();
        cyc();
        check("rs_sleeping", {31'd0, sleeping}, 32'd1);
        rst_n = 1'b0;
        #1;
        reset_checks("rst2");
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rs_valid0", {31'd0, inst_valid}, 32'd0);
        fetch_cycles(2, 32'h0);
        check("rs_valid2", {31'd0, inst_valid}, 32'd1);
        fetch_cycles(3, 32'h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_queue.md
# ifetch_queue

Fetch stage directly upstream of the dual-SPRAM instruction memory. It owns the program counter, drives the byte fetch address and the Stand-by request into the instruction memory, and captures the returned 32-bit words, one cycle later, into a small tagged queue. Decode consumes that queue over a valid/ready handshake. Branch redirects flush the queue, and WFI sleep/wake sequencing lives here so the SPRAMs sit in Stand-by only while the core is idle.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default 2: queue entries; power of two, ≥2.
- `clk` in 1: core clock, shared with instruction memory.
- `rst_n` in 1: reset, asynchronous, active-low.
- `redirect_valid` in 1: branch/jump/trap redirect, one-cycle pulse.
- `redirect_pc` in 32: redirect target; bits [1:0] ignored (treated as 0).
- `wfi_req` in 1: core retired WFI, one-cycle pulse.
- `wfi_pc` in 32: resume address after WFI; bits [1:0] ignored.
- `irq_pending` in 1: level, wakes from sleep.
- `imem_addr` out 32: byte fetch address to instruction memory.
- `imem_wfi` out 1: Stand-by request to instruction memory.
- `imem_rdata` in 32: instruction word for the address presented in the previous cycle.
- `inst_valid` out 1: head of queue valid.
- `inst_ready` in 1: decode accepts head.
- `inst_data` out 32: head instruction.
- `inst_pc` out 32: head instruction address.
- `sleeping` out 1: high in SLEEP.

## Operation
- State machine: RUN, SLEEP, WAKE. Reset state is RUN.
- `imem_addr` = `fetch_pc` register, driven combinationally. Bits [1:0] are always 0.
- Issue: in RUN, fetch issues when `count − pop + inflight < DEPTH`, where pop = `inst_valid & inst_ready`. On issue, `fetch_pc += 4` (wraps modulo 2^32), the `inflight` flag is set, and the issued pc is tagged.
- Capture: in the cycle after an issue, `imem_rdata` plus its tag are written into the queue, unless a discard is marked.
- Queue: FIFO. Head drives `inst_data`/`inst_pc`; pop and push may occur in the same cycle.
- Redirect (highest priority, any state):
  - queue flushed, in-flight word marked discard, `fetch_pc` ← `redirect_pc`, no issue that cycle;
  - in SLEEP, moves to WAKE;
  - if coincident with `wfi_req`, redirect wins and `wfi_req` is dropped.
- WFI in RUN:
  - queue flushed, in-flight discarded, `fetch_pc` ← `wfi_pc`;
  - if `irq_pending` is already high, stays RUN (acts as a redirect); otherwise → SLEEP.
- SLEEP: `imem_wfi`=1, `sleeping`=1, no issue, no capture. `irq_pending`=1 or redirect → WAKE.
- WAKE: `imem_wfi`=0, no issue for exactly one cycle (Stand-by exit), then → RUN.
- `wfi_req` outside RUN is ignored.

## Timing
- Reset values: `fetch_pc`=`RESET_PC`, queue empty, `inflight`=0, `inst_valid`=0, `imem_wfi`=0, `sleeping`=0, `inst_data`/`inst_pc` = 0.
- First issue happens in the first clock edge after `rst_n` deasserts.
- Fetch latency: address presented in cycle N, data captured at end of N+1, `inst_valid` high in N+2.
- Redirect latency: redirect in cycle 0 → target on `imem_addr` in cycle 1 → `inst_valid` with `inst_pc`=target in cycle 3.
- Throughput: one instruction per cycle sustained while `inst_ready`=1 (any `DEPTH` ≥2).
- Back-pressure: with `inst_ready`=0, exactly `DEPTH` words are accepted, then `imem_addr` holds. No word is ever lost or duplicated.
- Sleep timing: `imem_wfi` rises the cycle after `wfi_req`; it falls the cycle after `irq_pending` is first sampled high; first post-wake issue occurs 2 cycles after `irq_pending` is sampled.
- Reset asserted mid-operation: all state returns immediately to the reset values; any in-flight word is dropped.

## Configuration
- `IFETCH_SLEEP_CNT_EN` defined:
  - adds output `sleep_cycles` out 32, which counts clock cycles spent in SLEEP;
  - saturates at 32'hFFFF_FFFF;
  - reset to 0 only by `rst_n`.
- Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset release, `RESET_PC`=0, `inst_ready`=1 → `imem_addr` 0,4,8,… on consecutive cycles; `inst_valid` from cycle 2 with `inst_pc` 0,4,8 and matching `inst_data`.
- `inst_ready`=0 for 10 cycles, `DEPTH`=2 → queue holds pc 0 and 4, `imem_addr` stuck at 8; releasing `inst_ready` delivers 0,4,8 with no gaps or duplicates.
- `redirect_valid` with `redirect_pc`=0x100 while the queue is full and a fetch is in flight → old words discarded; next `inst_valid` is exactly 3 cycles later with `inst_pc`=0x100.
- `wfi_req` with `wfi_pc`=0x40 and `irq_pending`=0, then `irq_pending`=1 after 20 cycles → `imem_wfi`/`sleeping` high for 20 cycles; first post-wake `imem_addr`=0x40, two cycles after `irq_pending`; with the macro defined, `sleep_cycles`=20.
- `wfi_req` and `redirect_valid` (`redirect_pc`=0x200) in the same cycle → no sleep, `imem_wfi` stays 0, fetch resumes at 0x200. Separately, `wfi_req` with `irq_pending` already 1 → stays RUN, fetch resumes at `wfi_pc`.
- `rst_n` pulsed low in SLEEP → `imem_wfi`=0, `inst_valid`=0 immediately; fetch restarts at `RESET_PC`.
